// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the main-RAM controller.
//   state_e   : controller FSM states
//   len_e     : data-port access length encoding
//   req_t     : request payload latched at accept (owner, direction, bytes, write data)
//   len_bytes : maps a length code to a byte count (1/2/4; code 3 counts as a word)
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RAM_W  = 8;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LANES  = DATA_W / RAM_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [LEN_W-1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd2
  } len_e;

  typedef struct packed {
    logic              own_d;
    logic              wr;
    logic [CNT_W-1:0]  n;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic [CNT_W-1:0] len_bytes(input logic [LEN_W-1:0] len);
    case (len)
      LEN_BYTE: return CNT_W'(1);
      LEN_HALF: return CNT_W'(2);
      default:  return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the requesters, the controller and the byte-wide RAM.
//   i_*   : instruction fetch port (word reads only)
//   d_*   : data port (1/2/4-byte reads and writes)
//   mem_* : byte-wide RAM port
// slave modport is the controller's view; master is the requester/RAM side.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  import mem_ctrl_pkg::*;

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_busy;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0]  d_len;
  logic [DATA_W-1:0] d_wdata;
  logic              d_busy;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic [RAM_W-1:0]  mem_din;
  logic [RAM_W-1:0]  mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_len, d_wdata, mem_din,
    output i_busy, i_ready, i_data, d_busy, d_ready, d_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_len, d_wdata, mem_din,
    input  i_busy, i_ready, i_data, d_busy, d_ready, d_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: address/offset generator, write-byte mux and read lane capture.
//   clock, reset : clock and async active-low reset
//   clr          : clear all read lanes (new transfer)
//   cap          : capture mem_din into lane idx-2
//   idx          : transfer counter (byte offset for address/write mux)
//   base         : latched start address
//   wdata        : latched write word
//   mem_din      : RAM read byte
//   addr_c       : base + idx, wraps modulo 2^ADDR_W
//   wbyte_c      : write byte selected by idx
//   word_c       : assembled word including the byte being captured this cycle
module mem_ctrl_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              cap,
  input  logic [CNT_W-1:0]  idx,
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RAM_W-1:0]  mem_din,
  output logic [ADDR_W-1:0] addr_c,
  output logic [RAM_W-1:0]  wbyte_c,
  output logic [DATA_W-1:0] word_c
);

  logic [LANES-1:0][RAM_W-1:0] lanes;
  logic [1:0]                  lane;

  // Read data arrives one cycle after its address, so idx=2 lands in lane 0.
  assign lane    = 2'(idx - CNT_W'(2));
  assign addr_c  = base + ADDR_W'(idx);
  assign wbyte_c = wdata[RAM_W*idx[1:0] +: RAM_W];

  // Lane capture; cleared per transfer so short reads come out zero-extended.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lanes <= '0;
    end else if (clr) begin
      lanes <= '0;
    end else if (cap) begin
      lanes[lane] <= mem_din;
    end
  end

  // Bypass the byte arriving this cycle so the final word is ready one edge earlier.
  always_comb begin
    word_c = lanes;
    if (cap) begin
      word_c[RAM_W*lane +: RAM_W] = mem_din;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Main-RAM controller: arbitrates instruction and data requests onto the byte RAM,
// serialises each into byte accesses and returns a one-cycle ready pulse.
//   clock : system clock
//   reset : async active-low reset
//   bus   : mem_ctrl_if.slave (i_* fetch port, d_* data port, mem_* RAM port)
// Parameters: ADDR_W address width; D_FIRST=1 gives the data port priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter bit          D_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  mem_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [RAM_W-1:0]  mem_dout_q, mem_dout_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              d_req_c, busy_c, i_busy_c, d_busy_c, i_acc_c, d_acc_c;
  logic              lane_clr_c, lane_cap_c;
  logic [ADDR_W-1:0] seq_addr_c;
  logic [RAM_W-1:0]  seq_wbyte_c;
  logic [DATA_W-1:0] seq_word_c;

  // Arbitration: busy flags are combinational so the loser sees them in the same cycle.
  assign d_req_c  = bus.d_read | bus.d_write;
  assign busy_c   = (state_q != ST_IDLE);
  assign i_busy_c = busy_c || (D_FIRST && d_req_c);
  assign d_busy_c = busy_c || (!D_FIRST && bus.i_read);
  assign i_acc_c  = bus.i_read && !i_busy_c;
  assign d_acc_c  = d_req_c && !d_busy_c;

  mem_ctrl_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clock   (clock),
    .reset   (reset),
    .clr     (lane_clr_c),
    .cap     (lane_cap_c),
    .idx     (cnt_q),
    .base    (addr_q),
    .wdata   (req_q.wdata),
    .mem_din (bus.mem_din),
    .addr_c  (seq_addr_c),
    .wbyte_c (seq_wbyte_c),
    .word_c  (seq_word_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = 1'b0;
    mem_dout_d = '0;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    i_data_d   = '0;
    d_rdata_d  = '0;
    lane_clr_c = 1'b0;
    lane_cap_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_acc_c) begin
          req_d.own_d = 1'b1;
          req_d.wr    = bus.d_write;
          req_d.n     = len_bytes(bus.d_len);
          req_d.wdata = bus.d_wdata;
          addr_d      = bus.d_addr;
        end else if (i_acc_c) begin
          req_d.own_d = 1'b0;
          req_d.wr    = 1'b0;
          req_d.n     = CNT_W'(4);
          req_d.wdata = '0;
          addr_d      = bus.i_addr;
        end
        if (d_acc_c || i_acc_c) begin
          cnt_d      = CNT_W'(1);
          lane_clr_c = 1'b1;
          mem_a_d    = addr_d;
          if (req_d.wr) begin
            state_d    = ST_WR;
            mem_wr_d   = 1'b1;
            mem_dout_d = req_d.wdata[RAM_W-1:0];
          end else begin
            state_d = ST_RD;
          end
        end
      end

      // cnt = cycle number k; byte k-2 arrives in cycle k, one extra cycle after the last address.
      ST_RD: begin
        lane_cap_c = (cnt_q >= CNT_W'(2));
        cnt_d      = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q < req_q.n) begin
          mem_a_d = seq_addr_c;
        end
        if (cnt_q == CNT_W'(req_q.n + CNT_W'(1))) begin
          state_d = ST_DONE;
          if (req_q.own_d) begin
            d_ready_d = 1'b1;
            d_rdata_d = seq_word_c;
          end else begin
            i_ready_d = 1'b1;
            i_data_d  = seq_word_c;
          end
        end
      end

      ST_WR: begin
        if (cnt_q < req_q.n) begin
          mem_a_d    = seq_addr_c;
          mem_wr_d   = 1'b1;
          mem_dout_d = seq_wbyte_c;
          cnt_d      = CNT_W'(cnt_q + CNT_W'(1));
        end else begin
          state_d   = ST_DONE;
          d_ready_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears mem_wr immediately, aborting any transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      i_data_q   <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      i_data_q   <= i_data_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_busy   = i_busy_c;
  assign bus.d_busy   = d_busy_c;
  assign bus.i_ready  = i_ready_q;
  assign bus.i_data   = i_data_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_dout = mem_dout_q;

endmodule
